// File: rtl/avg_seq_ctrl.sv
// avg_seq_ctrl: serial NSAMP-sample averager, one shared adder + 1-bit shifter.
// Define AVG_ROUND_EN to add an RND state for round-half-up results.
module avg_seq_ctrl #(
  parameter int DATAWIDTH = 16,
  parameter int ACCWIDTH  = 32,
  parameter int NSAMP     = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [7:0]           sa,
  input  logic [DATAWIDTH-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [DATAWIDTH-1:0] avg,
  output logic                 Done,
  output logic                 Busy
);

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    RND,
    SHIFT,
    DONE
  } state_t;

  localparam logic [7:0]  LAST = 8'(NSAMP - 1);
  localparam logic [31:0] AWID = 32'(ACCWIDTH);

  state_t              state;
  logic [ACCWIDTH-1:0] acc;
  logic [ACCWIDTH-1:0] addend;
  logic [ACCWIDTH-1:0] sum;
  logic [7:0]          cnt;
  logic [7:0]          sh_q;
  logic                beat;
  logic                rnd_ok;

  assign beat   = din_valid & din_ready;
  assign rnd_ok = (sh_q != 8'd0) &&
                  ({24'd0, sh_q} <= AWID);

  // The single adder: samples in ACC, half-LSB in RND.
  always_comb begin
    addend = ACCWIDTH'(din);
`ifdef AVG_ROUND_EN
    if (state == RND)
      addend = ACCWIDTH'(1) << (sh_q - 8'd1);
`endif
  end

  assign sum = acc + addend;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sh_q      <= '0;
      avg       <= '0;
      Done      <= 1'b0;
      din_ready <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            acc       <= '0;
            cnt       <= '0;
            sh_q      <= sa;
            din_ready <= 1'b1;
            Busy      <= 1'b1;
            state     <= ACC;
          end
        end
        ACC: begin
          if (beat) begin
            acc <= sum;
            cnt <= cnt + 8'd1;
            if (cnt == LAST) begin
              din_ready <= 1'b0;
`ifdef AVG_ROUND_EN
              state <= RND;
`else
              state <= SHIFT;
`endif
            end
          end
        end
        RND: begin
          if (rnd_ok)
            acc <= sum;
          state <= SHIFT;
        end
        SHIFT: begin
          if (sh_q != 8'd0) begin
            acc  <= acc >> 1;
            sh_q <= sh_q - 8'd1;
          end else begin
            avg   <= acc[DATAWIDTH-1:0];
            Done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avg_seq_ctrl.sv
// tb_avg_seq_ctrl: randomized bench for avg_seq_ctrl against a sum/shift model.
// Build with AVG_ROUND_EN defined to check the rounding variant.
module tb_avg_seq_ctrl;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int NS = 8;
`ifdef AVG_ROUND_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  typedef logic [DW-1:0] smp_t [NS];

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          Start = 1'b0;
  logic [7:0]    sa = 8'd0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [DW-1:0] avg;
  logic          Done;
  logic          Busy;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  avg_seq_ctrl #(
    .DATAWIDTH(DW),
    .ACCWIDTH (AW),
    .NSAMP    (NS)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .sa       (sa),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .avg      (avg),
    .Done     (Done),
    .Busy     (Busy)
  );

  // Reference: plain sum, optional half-LSB add, wrap, shift, truncate.
  function automatic logic [DW-1:0] model(input smp_t s, input int sh);
    logic [63:0] acc;
    acc = 64'd0;
    for (int i = 0; i < NS; i++) acc += 64'(s[i]);
    if (RB == 1 && sh != 0 && sh <= AW)
      acc += 64'd1 << (sh - 1);
    acc &= 64'hFFFF_FFFF;
    if (sh >= 64) acc = 64'd0;
    else acc = acc >> sh;
    return acc[DW-1:0];
  endfunction

  function automatic int exp_lat(input int sh);
    return sh + 2 + RB;
  endfunction

  // One full operation; lat counts cycles from the last beat to Done.
  task automatic run_op(input smp_t s, input int sh, input int stall,
                        input bit noise, output logic [DW-1:0] ga,
                        output int lat, output logic rdy1);
    int i;
    int guard;
    i = 0;
    guard = 0;
    @(negedge Clk);
    Start = 1'b1;
    sa = 8'(sh);
    din_valid = noise;
    din = 16'hFFFF;
    @(negedge Clk);
    Start = 1'b0;
    while (i < NS && guard < 2000) begin
      if (noise) Start = 1'($urandom_range(1));
      din_valid = ($urandom_range(99) < stall) ? 1'b0 : 1'b1;
      din = din_valid ? s[i] : 16'($urandom);
      if (din_valid && din_ready) i++;
      guard++;
      @(negedge Clk);
    end
    lat = 1;
    din_valid = 1'b0;
    Start = 1'b0;
    rdy1 = din_ready;
    while (!Done && lat < 400) begin
      if (noise) Start = 1'($urandom_range(1));
      @(negedge Clk);
      lat++;
    end
    Start = 1'b0;
    ga = avg;
  endtask

  task automatic test_basic();
    smp_t s;
    logic [DW-1:0] ga;
    int lat;
    logic r1;
    for (int i = 0; i < NS; i++) s[i] = 16'(i + 1);
    run_op(s, 3, 0, 1'b0, ga, lat, r1);
    tests++;
    if (ga !== model(s, 3)) begin
      fails++;
      $display("FAIL basic_avg got %0d want %0d", ga, model(s, 3));
    end
    tests++;
    if (lat !== exp_lat(3)) begin
      fails++;
      $display("FAIL basic_lat got %0d want %0d", lat, exp_lat(3));
    end
    tests++;
    if (r1 !== 1'b0) begin
      fails++;
      $display("FAIL basic_ready_after got %b want 0", r1);
    end
    repeat (3) @(negedge Clk);
    tests++;
    if (Done !== 1'b0 || Busy !== 1'b0 || avg !== model(s, 3)) begin
      fails++;
      $display("FAIL basic_hold got done=%b busy=%b avg=%0d want 0 0 %0d",
               Done, Busy, avg, model(s, 3));
    end
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Start = 1'b1;
    sa = 8'd3;
    @(negedge Clk);
    Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din_valid = 1'b1;
      din = 16'(10 + i);
      @(negedge Clk);
    end
    din_valid = 1'b0;
    #2 Rst = 1'b0;
    #1;
    tests++;
    if (Busy !== 1'b0 || Done !== 1'b0 || avg !== '0 || din_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_async got busy=%b done=%b avg=%0d rdy=%b want 0 0 0 0",
               Busy, Done, avg, din_ready);
    end
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    tests++;
    if (Busy !== 1'b0 || din_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle got busy=%b rdy=%b want 0 0", Busy, din_ready);
    end
  endtask

  task automatic test_stalls();
    smp_t s;
    logic [DW-1:0] ga;
    int lat;
    logic r1;
    for (int i = 0; i < NS; i++) s[i] = 16'(i + 1);
    run_op(s, 3, 50, 1'b0, ga, lat, r1);
    tests++;
    if (ga !== model(s, 3) || r1 !== 1'b0) begin
      fails++;
      $display("FAIL stall_avg got %0d rdy=%b want %0d rdy=0", ga, r1, model(s, 3));
    end
    tests++;
    if (lat !== exp_lat(3)) begin
      fails++;
      $display("FAIL stall_lat got %0d want %0d", lat, exp_lat(3));
    end
  endtask

  task automatic test_max();
    smp_t s;
    logic [DW-1:0] ga;
    int lat;
    logic r1;
    for (int i = 0; i < NS; i++) s[i] = 16'hFFFF;
    run_op(s, 3, 0, 1'b0, ga, lat, r1);
    tests++;
    if (ga !== model(s, 3)) begin
      fails++;
      $display("FAIL max_sa3 got %h want %h", ga, model(s, 3));
    end
    run_op(s, 0, 0, 1'b0, ga, lat, r1);
    tests++;
    if (ga !== 16'hFFF8) begin
      fails++;
      $display("FAIL max_sum_low got %h want fff8", ga);
    end
  endtask

  task automatic test_shift_edges();
    smp_t s;
    logic [DW-1:0] ga;
    int lat;
    logic r1;
    for (int i = 0; i < NS; i++) s[i] = 16'(100 * (i + 1));
    run_op(s, 0, 0, 1'b0, ga, lat, r1);
    tests++;
    if (ga !== 16'd3600) begin
      fails++;
      $display("FAIL sa0_avg got %0d want 3600", ga);
    end
    tests++;
    if (lat !== exp_lat(0)) begin
      fails++;
      $display("FAIL sa0_lat got %0d want %0d", lat, exp_lat(0));
    end
    run_op(s, 40, 0, 1'b0, ga, lat, r1);
    tests++;
    if (ga !== '0) begin
      fails++;
      $display("FAIL sa40_avg got %0d want 0", ga);
    end
    tests++;
    if (lat !== exp_lat(40)) begin
      fails++;
      $display("FAIL sa40_lat got %0d want %0d", lat, exp_lat(40));
    end
  endtask

  task automatic test_protocol();
    smp_t s;
    smp_t n;
    logic [DW-1:0] ga;
    int lat;
    logic r1;
    for (int i = 0; i < NS; i++) s[i] = 16'(i + 1);
    for (int i = 0; i < NS; i++) n[i] = 16'd9;
    @(negedge Clk);
    din_valid = 1'b1;
    din = 16'hFFFF;
    @(negedge Clk);
    tests++;
    if (din_ready !== 1'b0 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_valid got rdy=%b busy=%b want 0 0", din_ready, Busy);
    end
    din_valid = 1'b0;
    run_op(s, 3, 30, 1'b1, ga, lat, r1);
    tests++;
    if (ga !== model(s, 3) || lat !== exp_lat(3)) begin
      fails++;
      $display("FAIL start_noise got avg=%0d lat=%0d want %0d %0d",
               ga, lat, model(s, 3), exp_lat(3));
    end
    run_op(n, 3, 0, 1'b0, ga, lat, r1);
    tests++;
    if (ga !== 16'd9 || lat !== exp_lat(3)) begin
      fails++;
      $display("FAIL back_to_back got avg=%0d lat=%0d want 9 %0d",
               ga, lat, exp_lat(3));
    end
  endtask

  task automatic test_round();
    smp_t s;
    logic [DW-1:0] ga;
    int lat;
    logic r1;
    for (int i = 0; i < NS; i++) s[i] = '0;
    s[0] = 16'd5;
    s[1] = 16'd7;
    run_op(s, 3, 0, 1'b0, ga, lat, r1);
    tests++;
    if (ga !== 16'(1 + RB)) begin
      fails++;
      $display("FAIL round_12 got %0d want %0d", ga, 1 + RB);
    end
    s[0] = 16'd4;
    run_op(s, 3, 0, 1'b0, ga, lat, r1);
    tests++;
    if (ga !== 16'd1) begin
      fails++;
      $display("FAIL round_11 got %0d want 1", ga);
    end
  endtask

  task automatic test_random();
    smp_t s;
    logic [DW-1:0] ga;
    int lat;
    logic r1;
    int sh;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NS; i++) s[i] = 16'($urandom);
      sh = (k == 7) ? 33 : int'($urandom_range(20));
      run_op(s, sh, int'($urandom_range(60)), 1'($urandom_range(1)), ga, lat, r1);
      tests++;
      if (ga !== model(s, sh) || lat !== exp_lat(sh)) begin
        fails++;
        $display("FAIL rand_%0d got avg=%h lat=%0d want %h %0d",
                 k, ga, lat, model(s, sh), exp_lat(sh));
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    tests++;
    if (Busy !== 1'b0 || Done !== 1'b0 || avg !== '0 || din_ready !== 1'b0) begin
      fails++;
      $display("FAIL por_state got busy=%b done=%b avg=%0d rdy=%b want 0 0 0 0",
               Busy, Done, avg, din_ready);
    end
    Rst = 1'b1;
    test_basic();
    test_reset();
    test_basic();
    test_stalls();
    test_max();
    test_shift_edges();
    test_protocol();
    test_round();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
